mem_stage: RTL and testbench

- MEM stage of the 5-stage pipeline; consumes the EX/MEM register outputs and produces the MEM/WB register.
- Resolves conditional branches (beq/bne) and performs data-memory reads and writes over a req/ack bus that may take several cycles.
- Raises a stall that freezes all upstream stages while a memory access is outstanding.

---
 rtl/mem_stage_if.sv | 19 +
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, multi-cycle data-memory access with upstream stall, MEM/WB register.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES unacknowledged request cycles.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        BranchNE,
    input  logic        zero,
    input  logic [31:0] pc4branched,
    input  logic [31:0] ALUres,
    input  logic [31:0] rd2,
    input  logic [4:0]  instr,
    mem_stage_if.master dmem,
    output logic        stall_o,
    output logic        pcsrc_o,
    output logic [31:0] branch_target_o,
    output logic        wb_valid_o,
    output logic        MemtoRego,
    output logic        RegWriteo,
    output logic [31:0] readdata_o,
    output logic [31:0] ALUreso,
    output logic [4:0]  wreg_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("mem_stage: TIMEOUT_CYCLES must be in [1, 2^CNT_W)");
    end

    logic [0:0] state;
    logic       mem_op;
    logic       aligned;
    logic       misalign_c;
    logic       is_load;
    logic       req_active;
    logic       ack_ok;
    logic       timeout_now;
    logic       done;
    logic       pending;

    assign mem_op     = valid_i & (MemRead | MemWrite);
    assign aligned    = (ALUres[1:0] == 2'b00);
    assign misalign_c = mem_op & ~aligned;
    assign is_load    = MemRead & ~MemWrite;

    // The request starts combinationally in IDLE so a zero-wait ack completes in one cycle;
    // rst_n gates it so a reset mid-access drops the bus immediately.
    assign req_active = rst_n & ((state == REQ) | (mem_op & aligned));
    assign ack_ok     = req_active & dmem.dmem_ack;
    assign done       = ack_ok | timeout_now;
    assign pending    = req_active & ~done;

    assign dmem.dmem_req   = req_active;
    assign dmem.dmem_we    = req_active & MemWrite;
    assign dmem.dmem_addr  = ALUres;
    assign dmem.dmem_wdata = rd2;

    assign stall_o         = pending;
    assign pcsrc_o         = valid_i & ((Branch & zero) | (BranchNE & ~zero));
    assign branch_target_o = pc4branched;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    // cnt holds the number of unacknowledged request cycles already elapsed, including the first.
    assign timeout_now = req_active & ~dmem.dmem_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            cnt       <= pending ? cnt + 1'b1 : '0;
            bus_err_o <= timeout_now;
        end
    end
`else
    assign timeout_now = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wb_valid_o <= 1'b0;
            MemtoRego  <= 1'b0;
            RegWriteo  <= 1'b0;
            readdata_o <= '0;
            ALUreso    <= '0;
            wreg_o     <= '0;
            misalign_o <= 1'b0;
        end else begin
            state <= pending ? REQ : IDLE;
            if (pending) begin
                // Bubble into WB while the access is outstanding.
                wb_valid_o <= 1'b0;
                RegWriteo  <= 1'b0;
                misalign_o <= 1'b0;
            end else begin
                wb_valid_o <= valid_i;
                MemtoRego  <= MemtoReg;
                RegWriteo  <= valid_i & RegWrite & ~misalign_c & ~timeout_now;
                readdata_o <= (ack_ok & is_load) ? dmem.dmem_rdata : '0;
                ALUreso    <= ALUres;
                wreg_o     <= instr;
                misalign_o <= misalign_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, loads/stores with waits, misalign, branches, reset mid-access.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchNE, zero;
    logic [31:0] pc4branched, ALUres, rd2;
    logic [4:0]  instr;
    logic        stall_o, pcsrc_o, wb_valid_o, MemtoRego, RegWriteo, misalign_o, bus_err_o;
    logic [31:0] branch_target_o, readdata_o, ALUreso;
    logic [4:0]  wreg_o;

    int total = 0;
    int bad   = 0;

    mem_stage_if dif ();

    mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .BranchNE(BranchNE), .zero(zero),
        .pc4branched(pc4branched), .ALUres(ALUres), .rd2(rd2), .instr(instr), .dmem(dif),
        .stall_o(stall_o), .pcsrc_o(pcsrc_o), .branch_target_o(branch_target_o),
        .wb_valid_o(wb_valid_o), .MemtoRego(MemtoRego), .RegWriteo(RegWriteo),
        .readdata_o(readdata_o), .ALUreso(ALUreso), .wreg_o(wreg_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; MemtoReg = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
        Branch = 0; BranchNE = 0; zero = 0;
        pc4branched = '0; ALUres = '0; rd2 = '0; instr = '0;
        dif.dmem_ack = 0; dif.dmem_rdata = '0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_regwrite", RegWriteo, 0);
        chk("rst_readdata", readdata_o, 0);
        chk("rst_alures", ALUreso, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_req", dif.dmem_req, 0);
        rst_n = 1;
        tick();

        // zero-wait load
        valid_i = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; ALUres = 32'h100; instr = 5'd5;
        dif.dmem_ack = 1; dif.dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("zw_req", dif.dmem_req, 1);
        chk("zw_we", dif.dmem_we, 0);
        chk("zw_addr", dif.dmem_addr, 32'h100);
        chk("zw_stall", stall_o, 0);
        tick();
        chk("zw_rdata", readdata_o, 32'hDEADBEEF);
        chk("zw_wb_valid", wb_valid_o, 1);
        chk("zw_wreg", wreg_o, 5);
        chk("zw_regwrite", RegWriteo, 1);
        chk("zw_memtoreg", MemtoRego, 1);
        idle_inputs();
        tick();
        chk("bubble_wb_valid", wb_valid_o, 0);
        chk("bubble_regwrite", RegWriteo, 0);

        // store acknowledged on its 4th request cycle
        valid_i = 1; MemWrite = 1; ALUres = 32'h24; rd2 = 32'h12345678; instr = 5'd9;
        #1;
        chk("st_req", dif.dmem_req, 1);
        chk("st_we", dif.dmem_we, 1);
        chk("st_addr", dif.dmem_addr, 32'h24);
        chk("st_wdata", dif.dmem_wdata, 32'h12345678);
        chk("st_stall_c1", stall_o, 1);
        for (int i = 2; i <= 3; i++) begin
            tick();
            chk("st_wb_wait", wb_valid_o, 0);
            #1;
            chk("st_stall_wait", stall_o, 1);
            chk("st_we_wait", dif.dmem_we, 1);
        end
        tick();
        chk("st_wb_wait3", wb_valid_o, 0);
        dif.dmem_ack = 1;
        #1;
        chk("st_stall_ack", stall_o, 0);
        tick();
        chk("st_wb_valid", wb_valid_o, 1);
        chk("st_readdata", readdata_o, 0);
        chk("st_regwrite", RegWriteo, 0);
        idle_inputs();

        // misaligned load
        valid_i = 1; MemRead = 1; RegWrite = 1; ALUres = 32'h102; instr = 5'd7;
        #1;
        chk("mis_req", dif.dmem_req, 0);
        chk("mis_stall", stall_o, 0);
        tick();
        chk("mis_regwrite", RegWriteo, 0);
        chk("mis_wb_valid", wb_valid_o, 1);
        chk("mis_pulse", misalign_o, 1);
        idle_inputs();
        tick();
        chk("mis_pulse_end", misalign_o, 0);

        // non-memory pass-through
        valid_i = 1; RegWrite = 1; ALUres = 32'h0000ABCD; instr = 5'd3;
        tick();
        chk("pt_wb_valid", wb_valid_o, 1);
        chk("pt_regwrite", RegWriteo, 1);
        chk("pt_alures", ALUreso, 32'h0000ABCD);
        chk("pt_wreg", wreg_o, 3);
        idle_inputs();

        // branches
        valid_i = 1; Branch = 1; zero = 1; pc4branched = 32'h4000;
        #1;
        chk("beq_taken", pcsrc_o, 1);
        chk("br_target", branch_target_o, 32'h4000);
        Branch = 0; BranchNE = 1;
        #1;
        chk("bne_not_taken", pcsrc_o, 0);
        zero = 0;
        #1;
        chk("bne_taken", pcsrc_o, 1);
        valid_i = 0;
        #1;
        chk("br_invalid", pcsrc_o, 0);
        idle_inputs();

        // ack while idle is ignored
        dif.dmem_ack = 1; dif.dmem_rdata = 32'h55;
        #1;
        chk("idle_ack_req", dif.dmem_req, 0);
        tick();
        chk("idle_ack_wb", wb_valid_o, 0);
        chk("idle_ack_rdata", readdata_o, 0);
        idle_inputs();

        // back-to-back loads: first with one wait, second zero-wait
        valid_i = 1; MemRead = 1; RegWrite = 1; ALUres = 32'h200; instr = 5'd1;
        tick();
        dif.dmem_ack = 1; dif.dmem_rdata = 32'h11;
        #1;
        chk("b2b_stall_ack", stall_o, 0);
        tick();
        chk("b2b_rdata1", readdata_o, 32'h11);
        ALUres = 32'h204; instr = 5'd2; dif.dmem_rdata = 32'h22;
        #1;
        chk("b2b_req2", dif.dmem_req, 1);
        chk("b2b_addr2", dif.dmem_addr, 32'h204);
        tick();
        chk("b2b_rdata2", readdata_o, 32'h22);
        chk("b2b_wreg2", wreg_o, 2);
        idle_inputs();

        // reset in the middle of an access
        valid_i = 1; MemRead = 1; RegWrite = 1; ALUres = 32'h300; instr = 5'd4;
        tick();
        chk("rm_req_before", dif.dmem_req, 1);
        rst_n = 0;
        #1;
        chk("rm_req", dif.dmem_req, 0);
        chk("rm_stall", stall_o, 0);
        chk("rm_wb_valid", wb_valid_o, 0);
        chk("rm_readdata", readdata_o, 0);
        chk("rm_wreg", wreg_o, 0);
        idle_inputs();
        tick();
        rst_n = 1;
        dif.dmem_ack = 1; dif.dmem_rdata = 32'h77;
        tick();
        chk("rm_late_ack_wb", wb_valid_o, 0);
        chk("rm_late_ack_rdata", readdata_o, 0);
        idle_inputs();

`ifdef MEM_TIMEOUT_EN
        valid_i = 1; MemRead = 1; RegWrite = 1; ALUres = 32'h40; instr = 5'd6;
        #1;
        chk("to_req_c1", dif.dmem_req, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("to_req_wait", dif.dmem_req, 1);
            chk("to_wb_wait", wb_valid_o, 0);
        end
        #1;
        chk("to_stall_last", stall_o, 0);
        tick();
        idle_inputs();
        #1;
        chk("to_req_dropped", dif.dmem_req, 0);
        chk("to_bus_err", bus_err_o, 1);
        chk("to_regwrite", RegWriteo, 0);
        chk("to_wb_valid", wb_valid_o, 1);
        tick();
        chk("to_bus_err_end", bus_err_o, 0);
`else
        chk("bus_err_tied", bus_err_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
